// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM driving a shared ALU / unified memory datapath.
// Optional macro RV_PERF_CNT_EN adds cycle and retired-instruction counters.
module rv_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [3:0]       state_o,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] alu_funct;

    // Ungated strobes; reset forces them low below.
    logic pc_write_raw;
    logic ir_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic mem_req_raw;
    logic done_raw;
    logic illegal_raw;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU operation for R/I-type execute; sub only for R-type funct7b5.
    always_comb begin
        alu_funct = ALU_ADD;
        case (funct3)
            3'b000:  alu_funct = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Next-state logic and Moore datapath controls.
    always_comb begin
        state_d       = S_FETCH;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        mem_req_raw   = 1'b0;
        done_raw      = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                state_d      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW:   state_d = S_MEMADR;
                    OP_SW:   state_d = S_MEMADR;
                    OP_R:    state_d = S_EXECR;
                    OP_I:    state_d = S_EXECI;
                    OP_BEQ:  state_d = S_BEQ;
                    OP_JAL:  state_d = S_JAL;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                AdrSrc      = 1'b1;
                state_d     = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = mem_ready;
                state_d       = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_funct;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b00;
                ALUControl   = ALU_SUB;
                pc_write_raw = Zero;
                done_raw     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite    = pc_write_raw & ~rst;
    assign IRWrite    = ir_write_raw & ~rst;
    assign MemWrite   = mem_write_raw & ~rst;
    assign RegWrite   = reg_write_raw & ~rst;
    assign mem_req    = mem_req_raw & ~rst;
    assign instr_done = done_raw & ~rst;
    assign illegal_op = illegal_raw & ~rst;
    assign state_o    = state_q;

`ifdef RV_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // Free-running performance counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (instr_done) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: vector table, directed
// corner sequences and random stimulus against an instruction-path model.
module tb_rv_multicycle_ctrl;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7b5 = 1'b0;
    logic             Zero = 1'b0;
    logic             mem_ready = 1'b1;
    logic             mem_req;
    logic             PCWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic [1:0]       ImmSrc;
    logic [3:0]       state_o;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .state_o(state_o),
        .instr_done(instr_done), .illegal_op(illegal_op),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       mw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       done;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        int          n;
        logic [19:0] sts;
        logic [2:0]  alu;
        logic [1:0]  imm;
    } vec_t;

    vec_t vt[15];
    int   route[$];

    function automatic ctl_t act_out();
        ctl_t a;
        a.st = state_o; a.req = mem_req; a.pcw = PCWrite;
        a.adr = AdrSrc; a.irw = IRWrite; a.mw = MemWrite;
        a.rw = RegWrite; a.rs = ResultSrc; a.sa = ALUSrcA;
        a.sb = ALUSrcB; a.alu = ALUControl; a.imm = ImmSrc;
        a.done = instr_done; a.ill = illegal_op;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z,
                         input logic mr, input logic r);
        @(negedge clk);
        op = o; funct3 = f3; funct7b5 = f7;
        Zero = z; mem_ready = mr; rst = r;
        #1;
    endtask

    task automatic do_reset();
        drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == OP_SW) return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [6:0] o,
                                           input logic [2:0] f3,
                                           input logic f7);
        if (f3 == 3'd0) return (o == OP_R && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    // State path of a whole instruction, from fetch to its last state.
    task automatic build_route(input logic [6:0] o);
        if (o == OP_LW)       route = {0, 1, 2, 3, 4};
        else if (o == OP_SW)  route = {0, 1, 2, 5};
        else if (o == OP_R)   route = {0, 1, 6, 8};
        else if (o == OP_I)   route = {0, 1, 7, 8};
        else if (o == OP_BEQ) route = {0, 1, 9};
        else if (o == OP_JAL) route = {0, 1, 10, 8};
        else                  route = {0, 1};
    endtask

    function automatic ctl_t exp_out(input int s, input logic [6:0] o,
                                     input logic [2:0] f3, input logic f7,
                                     input logic z, input logic mr,
                                     input logic r);
        ctl_t e;
        bit legal;
        legal = (o == OP_LW || o == OP_SW || o == OP_R ||
                 o == OP_I || o == OP_BEQ || o == OP_JAL);
        e = '0;
        e.st = 4'(s);
        e.imm = imm_ref(o);
        if (s == 0) begin
            e.req = 1; e.sb = 2'b10; e.rs = 2'b10;
            e.irw = mr; e.pcw = mr;
        end else if (s == 1) begin
            e.sa = 2'b01; e.sb = 2'b01; e.ill = !legal;
        end else if (s == 2) begin
            e.sa = 2'b10; e.sb = 2'b01;
        end else if (s == 3) begin
            e.req = 1; e.adr = 1;
        end else if (s == 4) begin
            e.rs = 2'b01; e.rw = 1; e.done = 1;
        end else if (s == 5) begin
            e.req = 1; e.adr = 1; e.mw = 1; e.done = mr;
        end else if (s == 6 || s == 7) begin
            e.sa = 2'b10; e.sb = (s == 7) ? 2'b01 : 2'b00;
            e.alu = alu_ref(o, f3, f7);
        end else if (s == 8) begin
            e.rw = 1; e.done = 1;
        end else if (s == 9) begin
            e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.done = 1;
        end else if (s == 10) begin
            e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1;
        end
        if (r) begin
            e.req = 0; e.pcw = 0; e.irw = 0; e.mw = 0;
            e.rw = 0; e.done = 0; e.ill = 0;
        end
        return e;
    endfunction

    initial begin
        logic [6:0] ro;
        logic [2:0] rf3;
        logic       rf7, rz, rmr, rr;
        int         pos, cyc_m, ret_m, sel;
        ctl_t       e;

        vt[0]  = '{OP_R,   3'd0, 1'b1, 1'b0, 4, 20'h08610, 3'b001, 2'd0};
        vt[1]  = '{OP_R,   3'd0, 1'b0, 1'b0, 4, 20'h08610, 3'b000, 2'd0};
        vt[2]  = '{OP_R,   3'd2, 1'b0, 1'b0, 4, 20'h08610, 3'b101, 2'd0};
        vt[3]  = '{OP_R,   3'd6, 1'b0, 1'b0, 4, 20'h08610, 3'b011, 2'd0};
        vt[4]  = '{OP_R,   3'd7, 1'b0, 1'b0, 4, 20'h08610, 3'b010, 2'd0};
        vt[5]  = '{OP_R,   3'd1, 1'b1, 1'b0, 4, 20'h08610, 3'b000, 2'd0};
        vt[6]  = '{OP_I,   3'd0, 1'b1, 1'b0, 4, 20'h08710, 3'b000, 2'd0};
        vt[7]  = '{OP_I,   3'd2, 1'b0, 1'b0, 4, 20'h08710, 3'b101, 2'd0};
        vt[8]  = '{OP_I,   3'd6, 1'b0, 1'b0, 4, 20'h08710, 3'b011, 2'd0};
        vt[9]  = '{OP_I,   3'd7, 1'b0, 1'b0, 4, 20'h08710, 3'b010, 2'd0};
        vt[10] = '{OP_LW,  3'd2, 1'b0, 1'b0, 5, 20'h43210, 3'b000, 2'd0};
        vt[11] = '{OP_SW,  3'd2, 1'b0, 1'b0, 4, 20'h05210, 3'b000, 2'd1};
        vt[12] = '{OP_BEQ, 3'd0, 1'b0, 1'b1, 3, 20'h00910, 3'b001, 2'd2};
        vt[13] = '{OP_JAL, 3'd0, 1'b0, 1'b0, 4, 20'h08A10, 3'b000, 2'd3};
        vt[14] = '{OP_BAD, 3'd0, 1'b0, 1'b0, 2, 20'h00010, 3'b000, 2'd0};

        // Reset: state 0, all strobes low even with mem_ready high.
        for (int k = 0; k < 2; k++) begin
            drive(7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("rst_state", 32'(state_o), 32'd0);
            chk("rst_strobes", 32'({mem_req, PCWrite, IRWrite, MemWrite,
                RegWrite, instr_done, illegal_op}), 32'd0);
        end

        // R-type sub.
        for (int k = 0; k < 5; k++) begin
            drive(OP_R, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("rsub_state", 32'(state_o), (k == 0) ? 0 : (k == 1) ? 1 :
                (k == 2) ? 6 : (k == 3) ? 8 : 0);
            chk("rsub_regwrite", 32'(RegWrite), (k == 3) ? 1 : 0);
            if (k == 2) chk("rsub_alu", 32'(ALUControl), 32'd1);
            if (k == 4) begin
`ifdef RV_PERF_CNT_EN
                chk("rsub_instret", instret_cnt, 32'd1);
`else
                chk("rsub_instret", instret_cnt, 32'd0);
`endif
            end
        end

        // lw with three stalled MEMREAD cycles.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            rmr = !(k >= 3 && k <= 5);
            drive(OP_LW, 3'd2, 1'b0, 1'b0, rmr, 1'b0);
            chk("lw_state", 32'(state_o), (k < 3) ? k : (k < 7) ? 3 :
                (k == 7) ? 4 : 0);
            if (k == 7) chk("lw_wb", 32'({ResultSrc, RegWrite}), 32'b011);
        end

        // beq taken then not taken.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            for (int k = 0; k < 3; k++)
                drive(OP_BEQ, 3'd0, 1'b0, (t == 0), 1'b1, 1'b0);
            chk("beq_state", 32'(state_o), 32'd9);
            chk("beq_pcwrite", 32'(PCWrite), (t == 0) ? 1 : 0);
            chk("beq_done", 32'(instr_done), 32'd1);
        end

        // Illegal opcode.
        do_reset();
        drive(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ill_pulse", 32'({illegal_op, instr_done}), 32'b10);
        drive(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ill_next", 32'({state_o, illegal_op, instr_done}), 32'h0);

        // jal.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("jal_state", 32'(state_o), (k < 2) ? k : (k == 2) ? 10 : 8);
            chk("jal_imm", 32'(ImmSrc), 32'd3);
            if (k == 2) chk("jal_pc", 32'({PCWrite, instr_done}), 32'b10);
            if (k == 3) chk("jal_done", 32'(instr_done), 32'd1);
        end

        // sw stalled in MEMWRITE, then reset.
        do_reset();
        for (int k = 0; k < 3; k++)
            drive(OP_SW, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sw_stall", 32'({state_o, MemWrite, instr_done}), 32'h16);
        drive(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sw_rst_mw", 32'({MemWrite, mem_req, instr_done}), 32'd0);
        drive(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sw_rst_state", 32'(state_o), 32'd0);
        chk("sw_rst_cycles", cycle_cnt, 32'd0);

        // Vector table, back to back with memory always ready.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < vt[i].n; k++) begin
                drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, 1'b1, 1'b0);
                chk($sformatf("vec%0d_state", i), 32'(state_o),
                    32'(vt[i].sts[4*k +: 4]));
                if (k == 1) chk($sformatf("vec%0d_imm", i),
                                32'(ImmSrc), 32'(vt[i].imm));
                if (k == 2) chk($sformatf("vec%0d_alu", i),
                                32'(ALUControl), 32'(vt[i].alu));
            end
        end

        // Random traffic against the instruction-path model.
        do_reset();
        pos = 0; cyc_m = 0; ret_m = 0;
        ro = OP_R; rf3 = '0; rf7 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (pos == 0) begin
                sel = int'($urandom % 8);
                case (sel)
                    0: ro = OP_LW;
                    1: ro = OP_SW;
                    2: ro = OP_R;
                    3: ro = OP_I;
                    4: ro = OP_BEQ;
                    5: ro = OP_JAL;
                    6: ro = OP_BAD;
                    default: ro = 7'($urandom);
                endcase
                rf3 = 3'($urandom);
                rf7 = 1'($urandom);
                build_route(ro);
            end
            rz = 1'($urandom);
            rmr = ($urandom % 4) != 0;
            rr = ($urandom % 64) == 0;
            drive(ro, rf3, rf7, rz, rmr, rr);
            e = exp_out(route[pos], ro, rf3, rf7, rz, rmr, rr);
            chk("rand_ctl", 32'(act_out()), 32'(e));
`ifdef RV_PERF_CNT_EN
            chk("rand_cycle", cycle_cnt, 32'(cyc_m));
            chk("rand_instret", instret_cnt, 32'(ret_m));
`else
            chk("rand_cycle", cycle_cnt, 32'd0);
            chk("rand_instret", instret_cnt, 32'd0);
`endif
            if (rr) begin
                pos = 0; cyc_m = 0; ret_m = 0;
            end else begin
                cyc_m++;
                if (e.done) ret_m++;
                if (!((route[pos] == 0 || route[pos] == 3 ||
                       route[pos] == 5) && !rmr)) pos++;
                if (pos >= route.size()) pos = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the shared RV32I datapath: one ALU, one unified instruction/data memory, and the register file.
- Replaces the per-instruction combinational control unit.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.
- Unified memory accesses use a req/ready handshake so slow memory can stall the sequence.

Parameters:
- CNT_W, default 32: width of the performance counters (used only with RV_PERF_CNT_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instruction opcode, Inst[6:0], taken from the instruction register.
- funct3  in  3  Inst[14:12].
- funct7b5  in  1  Inst[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access request.
- PCWrite  out  1  PC register load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register load enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 ALUOut, 01 memory data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  ALU B select: 00 RD2, 01 ImmExt, 10 constant 4.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- state_o  out  4  current state encoding.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- cycle_cnt  out  CNT_W  cycle counter.
- instret_cnt  out  CNT_W  retired-instruction counter.

Behaviour:
- Clock and reset:
  - Clock is clk; reset is rst, synchronous and active-high (fixed).
  - Reset sets state to FETCH.
  - While rst=1, force PCWrite, IRWrite, MemWrite, RegWrite, mem_req, instr_done and illegal_op to 0.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
  - Codes 11-15 are unreachable; if entered, go to FETCH next cycle.
- Output style: Moore outputs decoded from state, with only the gating listed below. Any unlisted output is 0.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add (computes the branch target).
  - Next state by op: 0000011 -> MEMADR; 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other op: illegal_op=1 for this cycle, next state FETCH.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add.
  - Next state MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD:
  - mem_req=1, AdrSrc=1, ResultSrc=00.
  - Hold until mem_ready=1, then go to MEMWB.
- MEMWB:
  - ResultSrc=01, RegWrite=1, instr_done=1; next state FETCH.
- MEMWRITE:
  - mem_req=1, AdrSrc=1, MemWrite=1.
  - Hold until mem_ready=1. In that cycle instr_done=1 and next state is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode; next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct decode; next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; next state FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=Zero; instr_done=1; next state FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next state ALUWB.
  - The return address is written in ALUWB; instr_done fires there only, not in JAL.
- Funct decode, selected by funct3:
  - 000: sub if (op[5] & funct7b5), else add. So addi is always add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other funct3 values: add.
- ImmSrc is decoded combinationally from op in every state: sw 01, beq 10, jal 11, all others 00.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- A reset asserted mid-instruction (including during a stalled MEMWRITE) abandons the instruction; no write enable fires in the reset cycle.

Optional Feature:
- Macro: RV_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments on every cycle with rst=0.
  - instret_cnt increments on every instr_done.
  - Both counters clear on rst and wrap modulo 2^CNT_W.
- Undefined: cycle_cnt and instret_cnt are tied to 0 and no counter registers exist.

Test Plan:
- Reset: hold rst=1 for 2 cycles with mem_ready=1 -> state_o=0, and all enables plus mem_req stay 0 throughout.
- R-type sub: op=0110011, funct3=000, funct7b5=1, mem_ready=1 -> states 0,1,6,8,0; ALUControl=001 in EXECR; RegWrite=1 only in ALUWB; instret_cnt=1 after 4 cycles (macro on).
- lw with stall: op=0000011, mem_ready=0 for 3 cycles while in MEMREAD -> state_o stays 3 for those cycles; then MEMWB with ResultSrc=01 and RegWrite=1; total 8 cycles from FETCH back to FETCH.
- beq: op=1100011 with Zero=1 -> PCWrite=1 in BEQ. Repeat with Zero=0 -> PCWrite=0 in BEQ. instr_done=1 in both cases.
- Illegal and jal: op=1111111 -> illegal_op pulses in DECODE and the next state is 0 with no instr_done. op=1101111 -> states 0,1,10,8; ImmSrc=11; PCWrite=1 in JAL.
- sw with reset mid-stall: op=0100011, mem_ready=0 in MEMWRITE, then assert rst -> MemWrite=0 in the reset cycle; next cycle state_o=0 and cycle_cnt=0.
